// File: rtl/spi_target_pkg.sv
// spi_target_pkg: shared types and constants for the SPI target bridge.
//   spi_target_state_t : frame decoder states (IDLE, CMD, ADDR, DATA)
//   CMD_READ_BIT       : command-byte bit that selects read (1) or write (0)
//   ID_BYTE_DEFAULT    : byte shifted out on MISO during the command byte
package spi_target_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CMD  = 2'd1,
      ST_ADDR = 2'd2,
      ST_DATA = 2'd3
   } spi_target_state_t;

   localparam int unsigned CMD_READ_BIT    = 7;
   localparam logic [7:0]  ID_BYTE_DEFAULT = 8'hA5;

endpackage

// File: rtl/spi_target_sync.sv
// spi_target_sync: brings the asynchronous SPI pins into the clk_i domain.
// Two flops per input, a third flop for edge detection, then registered
// pulse outputs, so a pin change shows up as a pulse 3 clk_i cycles later.
// Ports:
//   clk_i, reset_i : system clock, synchronous active-high reset
//   sclk_i, cs_ni, mosi_i : raw SPI pins
//   sclk_rise_o / sclk_fall_o : one-cycle SCLK edge pulses
//   cs_fall_o / cs_rise_o     : one-cycle chip-select edge pulses
//   cs_low_o                  : synchronized chip-select level (1 = selected)
//   mosi_o                    : MOSI aligned with sclk_rise_o
module spi_target_sync
   import spi_target_pkg::*;
(
   input  logic clk_i,
   input  logic reset_i,
   input  logic sclk_i,
   input  logic cs_ni,
   input  logic mosi_i,
   output logic sclk_rise_o,
   output logic sclk_fall_o,
   output logic cs_fall_o,
   output logic cs_rise_o,
   output logic cs_low_o,
   output logic mosi_o
);

   // [0] metastable, [1] synchronized, [2] previous (edge detect)
   logic [2:0] sclk_pipe_q;
   logic [2:0] cs_pipe_q;
   logic [1:0] mosi_pipe_q;

   logic sclk_rise_q, sclk_fall_q, cs_fall_q, cs_rise_q, cs_low_q, mosi_q;

   // The pin pipelines keep tracking the pins through reset so that a chip
   // select held low across reset is not mistaken for a fresh falling edge.
   always_ff @(posedge clk_i) begin
      sclk_pipe_q <= {sclk_pipe_q[1:0], sclk_i};
      cs_pipe_q   <= {cs_pipe_q[1:0], cs_ni};
      mosi_pipe_q <= {mosi_pipe_q[0], mosi_i};
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         sclk_rise_q <= 1'b0;
         sclk_fall_q <= 1'b0;
         cs_fall_q   <= 1'b0;
         cs_rise_q   <= 1'b0;
         cs_low_q    <= 1'b0;
         mosi_q      <= 1'b0;
      end else begin
         sclk_rise_q <= sclk_pipe_q[1] & ~sclk_pipe_q[2];
         sclk_fall_q <= ~sclk_pipe_q[1] & sclk_pipe_q[2];
         cs_fall_q   <= ~cs_pipe_q[1] & cs_pipe_q[2];
         cs_rise_q   <= cs_pipe_q[1] & ~cs_pipe_q[2];
         cs_low_q    <= ~cs_pipe_q[1];
         mosi_q      <= mosi_pipe_q[1];
      end
   end

   assign sclk_rise_o = sclk_rise_q;
   assign sclk_fall_o = sclk_fall_q;
   assign cs_fall_o   = cs_fall_q;
   assign cs_rise_o   = cs_rise_q;
   assign cs_low_o    = cs_low_q;
   assign mosi_o      = mosi_q;

endmodule

// File: rtl/spi_target_bridge.sv
// spi_target_bridge: SPI mode-0 target giving an external host read/write
// access to the 6502 system bus. Frame = command byte, address bytes (MSB
// first), then any number of data bytes; the frame ends when CS rises.
// Build option: SPI_TARGET_AUTOINC_EN -- when defined the bus address
// advances after every data byte; otherwise it stays fixed for the frame.
// Ports:
//   clk_i, reset_i              : system clock, synchronous active-high reset
//   spi_sclk_i, spi_cs_ni, spi_mosi_i : SPI host pins (asynchronous)
//   spi_miso_o, spi_miso_oe_o   : MISO data and output enable
//   bus_addr_o, bus_wdata_o     : bus address and write data
//   bus_we_o, bus_re_o          : one-cycle write / read strobes
//   bus_rdata_i                 : read data, valid the cycle after bus_re_o
//   txn_active_o                : frame decoder not idle
module spi_target_bridge
   import spi_target_pkg::*;
#(
   parameter int unsigned address_width = 16,
   parameter int unsigned data_width    = 8,
   parameter logic [7:0]  IdByte        = ID_BYTE_DEFAULT
) (
   input  logic                     clk_i,
   input  logic                     reset_i,
   input  logic                     spi_sclk_i,
   input  logic                     spi_cs_ni,
   input  logic                     spi_mosi_i,
   output logic                     spi_miso_o,
   output logic                     spi_miso_oe_o,
   output logic [address_width-1:0] bus_addr_o,
   output logic [data_width-1:0]    bus_wdata_o,
   output logic                     bus_we_o,
   output logic                     bus_re_o,
   input  logic [data_width-1:0]    bus_rdata_i,
   output logic                     txn_active_o
);

   localparam int unsigned ADDR_BYTES = address_width / 8;
   localparam logic [3:0]  LAST_ABYTE = 4'(ADDR_BYTES - 1);
`ifdef SPI_TARGET_AUTOINC_EN
   localparam logic [address_width-1:0] ADDR_ONE = address_width'(1);
`endif

   logic sclk_rise, sclk_fall, cs_fall, cs_rise, cs_low, mosi_s;

   spi_target_sync u_sync (
      .clk_i       (clk_i),
      .reset_i     (reset_i),
      .sclk_i      (spi_sclk_i),
      .cs_ni       (spi_cs_ni),
      .mosi_i      (spi_mosi_i),
      .sclk_rise_o (sclk_rise),
      .sclk_fall_o (sclk_fall),
      .cs_fall_o   (cs_fall),
      .cs_rise_o   (cs_rise),
      .cs_low_o    (cs_low),
      .mosi_o      (mosi_s)
   );

   spi_target_state_t        state_q, state_d;
   logic [2:0]               bit_cnt_q, bit_cnt_d;
   logic [6:0]               rx_q, rx_d;
   logic [7:0]               tx_q, tx_d;
   logic [address_width-1:0] addr_q, addr_d;
   logic [data_width-1:0]    wdata_q, wdata_d;
   logic                     we_q, we_d;
   logic                     re_q, re_d;
   logic                     cap_q, cap_d;
   logic                     rd_q, rd_d;
   logic [3:0]               abyte_q, abyte_d;

   logic [7:0]                 rx_byte;
   logic [address_width+7:0]   addr_shift;
   logic                       byte_done;

   assign rx_byte    = {rx_q, mosi_s};
   assign addr_shift = {addr_q, rx_byte};
   assign byte_done  = sclk_rise && (bit_cnt_q == 3'd7);

   always_comb begin
      state_d   = state_q;
      bit_cnt_d = bit_cnt_q;
      rx_d      = rx_q;
      tx_d      = tx_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      we_d      = 1'b0;
      re_d      = 1'b0;
      cap_d     = re_q;
      rd_d      = rd_q;
      abyte_d   = abyte_q;

`ifdef SPI_TARGET_AUTOINC_EN
      // The address advances one cycle after each strobe so it is stable
      // while the strobe is high.
      if (we_q || cap_q) begin
         addr_d = addr_q + ADDR_ONE;
      end
`endif

      // Read data arrives the cycle after bus_re_o; load it for the next byte.
      if (cap_q && (state_q != ST_IDLE)) begin
         tx_d = bus_rdata_i;
      end

      case (state_q)
         ST_IDLE: begin
            bit_cnt_d = 3'd0;
            if (cs_fall) begin
               state_d = ST_CMD;
               tx_d    = IdByte;
            end
         end
         default: begin
            if (sclk_rise) begin
               rx_d      = rx_byte[6:0];
               bit_cnt_d = bit_cnt_q + 3'd1;
            end
            // No shift at a byte boundary so a freshly loaded byte keeps bit 7.
            if (sclk_fall && (bit_cnt_q != 3'd0)) begin
               tx_d = {tx_q[6:0], 1'b0};
            end
            if (byte_done) begin
               tx_d = '0;
               case (state_q)
                  ST_CMD: begin
                     rd_d    = rx_byte[CMD_READ_BIT];
                     abyte_d = '0;
                     state_d = ST_ADDR;
                  end
                  ST_ADDR: begin
                     addr_d = addr_shift[address_width-1:0];
                     if (abyte_q == LAST_ABYTE) begin
                        state_d = ST_DATA;
                        re_d    = rd_q;
                     end else begin
                        abyte_d = abyte_q + 4'd1;
                     end
                  end
                  ST_DATA: begin
                     if (rd_q) begin
                        re_d = 1'b1;
                     end else begin
                        we_d    = 1'b1;
                        wdata_d = rx_byte;
                     end
                  end
                  default: ;
               endcase
            end
            if (cs_rise) begin
               state_d   = ST_IDLE;
               bit_cnt_d = 3'd0;
               tx_d      = '0;
               we_d      = 1'b0;
               re_d      = 1'b0;
            end
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q   <= ST_IDLE;
         bit_cnt_q <= '0;
         rx_q      <= '0;
         tx_q      <= '0;
         addr_q    <= '0;
         wdata_q   <= '0;
         we_q      <= 1'b0;
         re_q      <= 1'b0;
         cap_q     <= 1'b0;
         rd_q      <= 1'b0;
         abyte_q   <= '0;
      end else begin
         state_q   <= state_d;
         bit_cnt_q <= bit_cnt_d;
         rx_q      <= rx_d;
         tx_q      <= tx_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         we_q      <= we_d;
         re_q      <= re_d;
         cap_q     <= cap_d;
         rd_q      <= rd_d;
         abyte_q   <= abyte_d;
      end
   end

   assign spi_miso_o    = tx_q[7];
   assign spi_miso_oe_o = cs_low;
   assign bus_addr_o    = addr_q;
   assign bus_wdata_o   = wdata_q;
   assign bus_we_o      = we_q;
   assign bus_re_o      = re_q;
   assign txn_active_o  = (state_q != ST_IDLE);

endmodule

// File: doc/spi_target_bridge.md
# spi_target_bridge

SPI target (slave) that lets an external SPI host read and write the 6502 system bus, the target-side counterpart of the Ethernet SPI initiator. It samples SPI mode 0 (CPOL=0, CPHA=0) by oversampling in the system clock domain, decodes a command/address/data frame, and issues single-cycle bus strobes. It sits beside the UART as a second host-access path into `main_6502` address space.

## Interface
- `address_width`, default 16: bus address width. Must be a multiple of 8; the address phase is `address_width/8` bytes, MSB first.
- `data_width`, default 8: bus data width. Must be 8.
- `IdByte`, default 8'hA5: byte returned on MISO during the command byte.

Ports:
- `clk_i` in 1: system clock. One clock domain for the whole block.
- `reset_i` in 1: synchronous, active-high reset.
- `spi_sclk_i` in 1: SPI clock, asynchronous.
- `spi_cs_ni` in 1: chip select, active low, asynchronous.
- `spi_mosi_i` in 1: host-to-target data, asynchronous.
- `spi_miso_o` out 1: target-to-host data.
- `spi_miso_oe_o` out 1: MISO output enable. High while the synchronized CS is low.
- `bus_addr_o` out `address_width`: bus address.
- `bus_wdata_o` out 8: write data.
- `bus_we_o` out 1: one-cycle write strobe.
- `bus_re_o` out 1: one-cycle read strobe. `bus_rdata_i` is valid on the cycle after the strobe.
- `bus_rdata_i` in 8: read data.
- `txn_active_o` out 1: high whenever the FSM is not in IDLE.

## Operation
- Frame format: command byte, then address bytes, then any number of data bytes. The frame ends when CS rises.
- Command byte: bit7=1 selects read, bit7=0 selects write. Bits 6:0 are ignored.
- FSM states: IDLE, CMD, ADDR, DATA.
  - IDLE→CMD on the CS falling edge. On the same edge, `IdByte` loads into the TX shift register.
  - CMD→ADDR after the 8th rising edge of SCLK.
  - ADDR→DATA after the last address byte completes.
  - Any state→IDLE on the CS rising edge.
- Bit handling:
  - MOSI is sampled on the synchronized SCLK rising edge, MSB first.
  - `bit_cnt` counts rising edges from 0 to 7 and wraps to 0.
  - On a falling edge the TX shift register shifts left only if `bit_cnt != 0`. At byte boundaries it is not shifted, so a newly loaded byte is not lost.
  - `spi_miso_o` = TX shift register bit 7.
- Write: on the 8th rising edge of each data byte, pulse `bus_we_o` with the current `bus_addr_o` and the received byte, then advance the address.
- Read:
  - On the 8th rising edge of the last address byte, and of each data byte, pulse `bus_re_o`.
  - On the next cycle, capture `bus_rdata_i` into the TX shift register, then advance the address.
  - The first data byte returned is therefore the byte at the transmitted address.
- MISO returns 0 during address bytes and during write-data bytes.
- Abort: a CS rise mid-byte discards the partial byte. No bus strobe is issued for it.
- Address arithmetic: modulo 2^`address_width`, so 16'hFFFF+1 wraps to 16'h0000.

## Timing
- Synchronizer: two flops per SPI input, plus one more flop for edge detect. Input-to-edge latency is 3 `clk_i` cycles.
- SCLK frequency must not exceed `clk_i`/8, which gives at least 4 clocks per SCLK phase.
- The first SCLK rising edge must come at least 4 clocks after CS falls.
- Read path:
  - Rising-edge-detect cycle N: `bus_re_o` high.
  - Cycle N+1: rdata captured into the TX shift register.
  - Both complete before the next falling-edge detect (earliest N+4).
- `bus_we_o` and `bus_re_o` are single-cycle pulses and are never high together.
- Reset values: `spi_miso_o`=0, `spi_miso_oe_o`=0, `bus_addr_o`=0, `bus_wdata_o`=0, `bus_we_o`=0, `bus_re_o`=0, `txn_active_o`=0, FSM=IDLE.
- Reset asserted mid-frame: return to IDLE immediately. The block waits for a fresh CS falling edge, even if CS is still low when reset releases.

## Configuration
- `SPI_TARGET_AUTOINC_EN` defined: the address increments after every data byte, as described above.
- Not defined: the address stays fixed for the whole frame. All data bytes target the same address (FIFO-register style), and the increment logic is removed.

## Structure
- Package `spi_target_pkg` holds:
  - the FSM state enum (`spi_target_state_t`)
  - `CMD_READ_BIT` = 7
  - the default `IdByte` constant.
- Sub-module `spi_target_sync`: 2-FF synchronizers for SCLK, CS and MOSI, with registered rise/fall pulse outputs. It is instantiated once.

## Test plan
- CS low, command 8'h00, address 16'h0200, data 8'h11 8'h22 → `bus_we_o` pulses twice: 16'h0200 with 8'h11, then 16'h0201 with 8'h22.
- Command 8'h80, address 16'h0300, bus model returns 8'hAA then 8'hBB → MISO carries 8'hA5 during the command byte, 8'h00 during the address bytes, then 8'hAA and 8'hBB.
- Write burst at address 16'hFFFF with 2 bytes → writes land at 16'hFFFF, then 16'h0000. Without `SPI_TARGET_AUTOINC_EN`, both writes land at 16'hFFFF.
- CS rises after 4 bits of a write-data byte → no `bus_we_o` pulse, FSM returns to IDLE, and the next frame decodes correctly.
- `reset_i` pulsed during the address phase with CS held low → all outputs return to reset values. No strobes occur until CS rises and falls again.
- SCLK at exactly `clk_i`/8, 16-byte read burst → every byte matches the bus model, with no dropped or duplicated bits.
